// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch time base: FSM state encoding,
// the mm:ss.cc time record and its carry-chain increment.
package stopwatch_pkg;

    localparam int TIME_W  = 7;
    localparam int SMS_MAX = 99;
    localparam int SEC_MAX = 59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    typedef struct packed {
        logic [TIME_W-1:0] m;
        logic [TIME_W-1:0] s;
        logic [TIME_W-1:0] sms;
    } sw_time_t;

    // One centisecond step with carries into seconds and minutes; the minute
    // limit is handled by the caller.
    function automatic sw_time_t time_inc(input sw_time_t t);
        sw_time_t r;
        r = t;
        if (t.sms == TIME_W'(SMS_MAX)) begin
            r.sms = '0;
            if (t.s == TIME_W'(SEC_MAX)) begin
                r.s = '0;
                r.m = t.m + 1'b1;
            end else begin
                r.s = t.s + 1'b1;
            end
        end else begin
            r.sms = t.sms + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_timebase_rise_detect.sv
// Single-bit rising-edge detector: registers the previous level and flags a
// 0->1 transition for exactly one cycle.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev;

    // NOTE: sequential state uses non-blocking assignment so every reader sees
    // the value from the previous edge, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/stopwatch_timebase.sv
// Stopwatch time base: button edges drive an IDLE/RUN/PAUSE FSM, a prescaler
// generates centisecond ticks and a mm:ss.cc counter feeds the lap store.
// Optional build macro STOPWATCH_WRAP_EN: wrap to 00:00.00 at the limit
// instead of saturating.
module stopwatch_timebase
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 100,
    parameter int MAX_MIN     = 99
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_ss,
    input  logic              btn_lap,
    input  logic              btn_clr,
    output logic [TIME_W-1:0] m,
    output logic [TIME_W-1:0] s,
    output logic [TIME_W-1:0] sms,
    output logic              running,
    output logic              lap_stb,
    output logic              clr_stb,
    output logic              overflow
);

    localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam sw_time_t LIMIT_TIME = '{
        m:   TIME_W'(MAX_MIN),
        s:   TIME_W'(SEC_MAX),
        sms: TIME_W'(SMS_MAX)
    };

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("stopwatch_timebase: CLK_FREQ_HZ/TICK_HZ must be at least 2");
    end
    if (MAX_MIN < 0 || MAX_MIN > 127) begin : g_bad_max_min
        $error("stopwatch_timebase: MAX_MIN must be in 0..127");
    end

    sw_state_t        state;
    sw_state_t        state_nxt;
    logic [PRE_W-1:0] pre;
    sw_time_t         cnt;
    logic             pending;
    logic             ovf_q;
    logic             lap_q;
    logic             clr_q;

    logic ss_rise;
    logic lap_rise;
    logic clr_rise;
    logic lap_fire;
    logic clr_fire;
    logic tick;
    logic do_step;
    logic at_limit;

    rise_detect u_rise_ss (
        .clk   (clk),
        .reset (reset),
        .level (btn_ss),
        .rise  (ss_rise)
    );

    rise_detect u_rise_lap (
        .clk   (clk),
        .reset (reset),
        .level (btn_lap),
        .rise  (lap_rise)
    );

    rise_detect u_rise_clr (
        .clk   (clk),
        .reset (reset),
        .level (btn_clr),
        .rise  (clr_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        lap_fire  = 1'b0;
        clr_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (ss_rise) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                lap_fire = lap_rise;
                if (ss_rise) begin
                    state_nxt = PAUSE;
                end
            end
            PAUSE: begin
                // Clear beats a simultaneous start so no run begins from PAUSE.
                if (clr_rise) begin
                    state_nxt = IDLE;
                    clr_fire  = 1'b1;
                end else if (ss_rise) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign tick = (state == RUN) && (pre == PRE_LAST);

    // Prescaler phase survives PAUSE; a fresh run from IDLE starts at zero.
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            pre <= '0;
        end else if (state == RUN) begin
            pre <= tick ? '0 : pre + 1'b1;
        end
    end

    // The counter is frozen on the edge that raises lap_stb, so the lap store
    // sees a stable time; a tick landing there is replayed on the next edge.
    assign do_step  = !lap_fire && (tick || pending);
    assign at_limit = (cnt == LIMIT_TIME);

    always_ff @(posedge clk) begin
        if (reset || clr_fire) begin
            pending <= 1'b0;
        end else if (lap_fire) begin
            pending <= pending | tick;
        end else begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_fire) begin
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
`ifdef STOPWATCH_WRAP_EN
            ovf_q <= 1'b0;
            if (do_step) begin
                if (at_limit) begin
                    cnt   <= '0;
                    ovf_q <= 1'b1;
                end else begin
                    cnt <= time_inc(cnt);
                end
            end
`else
            if (do_step) begin
                if (at_limit) begin
                    ovf_q <= 1'b1;
                end else begin
                    cnt <= time_inc(cnt);
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lap_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            lap_q <= lap_fire;
            clr_q <= clr_fire;
        end
    end

    assign m        = cnt.m;
    assign s        = cnt.s;
    assign sms      = cnt.sms;
    assign running  = (state == RUN);
    assign lap_stb  = lap_q;
    assign clr_stb  = clr_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Self-checking bench for stopwatch_timebase: a cycle-level reference model
// derives the displayed time from the number of clock edges spent running.
module tb_stopwatch_timebase;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int TD      = CLK_HZ / TICK_HZ;
    localparam int MAX_MIN = 99;
    localparam int LIMIT   = (MAX_MIN * 60 + 59) * 100 + 99;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       btn_ss  = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clr = 1'b0;
    logic [6:0] m, s, sms;
    logic       running, lap_stb, clr_stb, overflow;

    logic       btn_ss2  = 1'b0;
    logic       btn_lap2 = 1'b0;
    logic       btn_clr2 = 1'b0;
    logic [6:0] m2, s2, sms2;
    logic       running2, lap_stb2, clr_stb2, overflow2;

    int checks = 0;
    int errors = 0;

    // Reference model state: 0 idle, 1 run, 2 pause.
    int mstate     = 0;
    int run_edges  = 0;
    int wraps_last = 0;
    bit p_ss, p_lap, p_clr;
    bit exp_lap, exp_clr;

    always #5 clk = ~clk;

    stopwatch_timebase #(
        .CLK_FREQ_HZ (CLK_HZ),
        .TICK_HZ     (TICK_HZ),
        .MAX_MIN     (MAX_MIN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_ss   (btn_ss),
        .btn_lap  (btn_lap),
        .btn_clr  (btn_clr),
        .m        (m),
        .s        (s),
        .sms      (sms),
        .running  (running),
        .lap_stb  (lap_stb),
        .clr_stb  (clr_stb),
        .overflow (overflow)
    );

    // Short-limit instance (00:59.99, two clocks per tick) to reach the limit quickly.
    stopwatch_timebase #(
        .CLK_FREQ_HZ (1000),
        .TICK_HZ     (500),
        .MAX_MIN     (0)
    ) dut_lim (
        .clk      (clk),
        .reset    (reset),
        .btn_ss   (btn_ss2),
        .btn_lap  (btn_lap2),
        .btn_clr  (btn_clr2),
        .m        (m2),
        .s        (s2),
        .sms      (sms2),
        .running  (running2),
        .lap_stb  (lap_stb2),
        .clr_stb  (clr_stb2),
        .overflow (overflow2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_time(input string tag, input int em, input int es, input int ems);
        check({tag, "_m"}, m, em);
        check({tag, "_s"}, s, es);
        check({tag, "_sms"}, sms, ems);
    endtask

    task automatic check_time2(input string tag, input int em, input int es, input int ems);
        check({tag, "_m"}, m2, em);
        check({tag, "_s"}, s2, es);
        check({tag, "_sms"}, sms2, ems);
    endtask

    // One clock: advance the model with the inputs the DUT sampled, then
    // compare every output of the main instance 1 time unit after the edge.
    task automatic step();
        bit r_ss, r_lap, r_clr;
        int ticks, shown, exp_ovf;
        @(posedge clk);
        exp_lap = 1'b0;
        exp_clr = 1'b0;
        if (reset) begin
            mstate     = 0;
            run_edges  = 0;
            wraps_last = 0;
            p_ss = 1'b0; p_lap = 1'b0; p_clr = 1'b0;
        end else begin
            r_ss  = btn_ss  && !p_ss;
            r_lap = btn_lap && !p_lap;
            r_clr = btn_clr && !p_clr;
            p_ss = btn_ss; p_lap = btn_lap; p_clr = btn_clr;
            case (mstate)
                0: if (r_ss) mstate = 1;
                1: begin
                    run_edges++;
                    exp_lap = r_lap;
                    if (r_ss) mstate = 2;
                end
                default: begin
                    if (r_clr) begin
                        mstate     = 0;
                        run_edges  = 0;
                        wraps_last = 0;
                        exp_clr    = 1'b1;
                    end else if (r_ss) begin
                        mstate = 1;
                    end
                end
            endcase
        end
        #1;
        ticks = (exp_lap ? run_edges - 1 : run_edges) / TD;
`ifdef STOPWATCH_WRAP_EN
        shown      = ticks % (LIMIT + 1);
        exp_ovf    = (ticks / (LIMIT + 1)) != wraps_last ? 1 : 0;
        wraps_last = ticks / (LIMIT + 1);
`else
        shown   = (ticks > LIMIT) ? LIMIT : ticks;
        exp_ovf = (ticks > LIMIT) ? 1 : 0;
`endif
        check("model_m", m, shown / 6000);
        check("model_s", s, (shown / 100) % 60);
        check("model_sms", sms, shown % 100);
        check("model_running", running, (mstate == 1) ? 1 : 0);
        check("model_lap_stb", lap_stb, exp_lap);
        check("model_clr_stb", clr_stb, exp_clr);
        check("model_overflow", overflow, exp_ovf);
    endtask

    // mask bit0 = start/stop, bit1 = lap, bit2 = clear; held for 'hold' clocks.
    task automatic press(input int mask, input int hold);
        btn_ss  = mask[0];
        btn_lap = mask[1];
        btn_clr = mask[2];
        repeat (hold) step();
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        btn_clr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_t;

        // Reset state.
        repeat (3) step();
        reset = 1'b0;
        step();
        check_time("reset", 0, 0, 0);
        check("reset_running", running, 0);
        check("reset_overflow", overflow, 0);

        // 1: start, 1000 clocks -> one second.
        press(1, 1);
        repeat (1000) step();
        check_time("one_sec", 0, 1, 0);
        check("one_sec_running", running, 1);

        // Back to IDLE via pause + clear.
        press(1, 1);
        press(4, 1);
        check("clr1_stb", clr_stb, 1);
        check_time("clr1", 0, 0, 0);
        step();
        check("clr1_stb_once", clr_stb, 0);

        // 2: pause holds the count, resume continues with phase kept.
        press(1, 1);
        repeat (250) step();
        press(1, 1);
        repeat (500) step();
        check_time("paused", 0, 0, 25);
        check("paused_running", running, 0);
        press(1, 1);
        repeat (50) step();
        check_time("resumed", 0, 0, 30);

        // 3: lap on the same edge as a tick.
        for (int i = 0; i < TD && ((run_edges + 1) % TD) != 0; i++) step();
        btn_lap = 1'b1;
        step();
        exp_t = (run_edges - 1) / TD;
        check("lap_tick_stb", lap_stb, 1);
        check_time("lap_tick_hold", exp_t / 6000, (exp_t / 100) % 60, exp_t % 100);
        step();
        exp_t = exp_t + 1;
        check("lap_tick_stb_once", lap_stb, 0);
        check_time("lap_tick_after", exp_t / 6000, (exp_t / 100) % 60, exp_t % 100);
        repeat (4) step();
        btn_lap = 1'b0;
        step();

        // 4: clear ignored in RUN, honoured in PAUSE.
        press(4, 2);
        check("clr_in_run_running", running, 1);
        press(1, 1);
        press(4, 1);
        check_time("clr_pause", 0, 0, 0);
        check("clr_pause_stb", clr_stb, 1);
        check("clr_pause_running", running, 0);
        step();
        check("clr_pause_stb_once", clr_stb, 0);

        // Simultaneous start/stop + lap in RUN, then start/stop + clear in PAUSE.
        press(1, 1);
        repeat (37) step();
        press(3, 1);
        check("sslap_stb", lap_stb, 1);
        check("sslap_running", running, 0);
        step();
        press(5, 1);
        check("ssclr_stb", clr_stb, 1);
        check("ssclr_running", running, 0);
        repeat (5) step();
        check("ssclr_stays_idle", running, 0);

        // Randomized button activity checked against the model every clock.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 4))
                0: repeat ($urandom_range(1, 60)) step();
                1: press(1, $urandom_range(1, 3));
                2: press(2, $urandom_range(1, 3));
                3: press(4, $urandom_range(1, 3));
                default: press($urandom_range(1, 7), $urandom_range(1, 3));
            endcase
            step();
        end

        // 6: reset in RUN mid-prescale.
        if (mstate != 1) press(1, 1);
        if (mstate != 1) press(1, 1);
        repeat (13) step();
        check("pre_reset_running", running, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_time("mid_reset", 0, 0, 0);
        check("mid_reset_running", running, 0);
        check("mid_reset_lap", lap_stb, 0);
        check("mid_reset_clr", clr_stb, 0);
        check("mid_reset_ovf", overflow, 0);
        step();

        // 5: limit on the short instance (00:59.99 after 5999 ticks).
        btn_ss2 = 1'b1;
        step();
        btn_ss2 = 1'b0;
        repeat (11996) step();
        check_time2("lim_9998", 0, 59, 98);
        check("lim_9998_ovf", overflow2, 0);
        repeat (2) step();
        check_time2("lim_9999", 0, 59, 99);
        check("lim_9999_ovf", overflow2, 0);
        repeat (2) step();
`ifdef STOPWATCH_WRAP_EN
        check_time2("lim_wrap", 0, 0, 0);
        check("lim_wrap_ovf", overflow2, 1);
        step();
        check("lim_wrap_ovf_pulse", overflow2, 0);
        repeat (20) step();
        check_time2("lim_wrap_cont", 0, 0, 10);
`else
        check_time2("lim_sat", 0, 59, 99);
        check("lim_sat_ovf", overflow2, 1);
        step();
        check("lim_sat_ovf_sticky", overflow2, 1);
        repeat (20) step();
        check_time2("lim_sat_hold", 0, 59, 99);
        check("lim_sat_ovf_hold", overflow2, 1);
`endif
        check("lim_running", running2, 1);
        btn_ss2 = 1'b1;
        step();
        btn_ss2 = 1'b0;
        btn_clr2 = 1'b1;
        step();
        btn_clr2 = 1'b0;
        check_time2("lim_clr", 0, 0, 0);
        check("lim_clr_ovf", overflow2, 0);
        check("lim_clr_stb", clr_stb2, 1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
